muldiv_ctrl: RTL and testbench
==============================

# muldiv_ctrl

Multi-cycle multiply/divide controller for the pipelined MIPS core. It accepts mult/multu/div/divu/mthi/mtlo from the E stage and holds the HI/LO registers. It models fixed multiply and divide latencies with a busy counter and raises a stall request to the hazard unit whenever a D-stage HI/LO instruction would collide with an operation in flight. Its HI/LO read port drives the E-stage result select mux.

## Interface
Parameters:
- MULT_CYCLES, 5, busy duration of mult/multu in cycles (legal range 1..15)
- DIV_CYCLES, 10, busy duration of div/divu in cycles (legal range 1..15)

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high
- op  in  3  E-stage operation: 000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 none
- a  in  32  E-stage rs operand (already forwarded)
- b  in  32  E-stage rt operand (already forwarded)
- d_md  in  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- rd_sel  in  1  read select: 0 LO, 1 HI
- rd_data  out  32  selected HI/LO register value
- busy  out  1  operation in flight
- stall  out  1  stall request to the hazard unit
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- States: IDLE, RUN. `cnt` is a 4-bit down-counter. `pend_hi` and `pend_lo` are 32-bit pending result registers.
- `start` = (op in 001..100) & IDLE. This is internal and combinational.
- IDLE with start:
  - Compute the result from a and b.
  - `pend_hi`/`pend_lo` <= result.
  - `cnt` <= MULT_CYCLES for mult/multu, DIV_CYCLES for div/divu.
  - Go to RUN.
- IDLE with op=101: hi <= a. With op=110: lo <= a. Both are single-cycle; busy stays 0.
- RUN:
  - `cnt` decrements each cycle.
  - On the edge where `cnt`==1: hi <= `pend_hi`, lo <= `pend_lo`, go to IDLE.
- RUN with any op≠000 (the hazard unit prevents this): the op is ignored. Operands, HI/LO and `cnt` are unaffected.
- Arithmetic:
  - mult: signed 32x32 to 64.
  - multu: unsigned 32x32 to 64.
  - {hi, lo} = product, with hi = bits 63:32.
  - div: lo = quotient truncated toward zero, hi = remainder, which takes the sign of the dividend a.
  - divu: unsigned quotient/remainder.
- Boundary cases:
  - b==0 on div/divu: the full DIV_CYCLES still elapse, and HI/LO keep their prior values at completion.
  - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- busy = (state==RUN).
- stall = d_md & (busy | start).
- rd_data = rd_sel ? hi : lo. This is combinational from the architectural registers only; pending values are never forwarded.

## Timing
- Reset: state IDLE, cnt=0, pend_hi=pend_lo=0, hi=lo=0. Therefore busy=0, stall=0, rd_data=0.
- Reset during RUN aborts the operation. The pending result is discarded and HI/LO become 0 on that edge.
- Start accepted at edge T:
  - busy is high for cycles T+1 .. T+N, where N is MULT_CYCLES or DIV_CYCLES.
  - hi/lo update at edge T+N.
  - busy is 0 from cycle T+N+1 (i.e. after edge T+N).
  - A back-to-back start is accepted at edge T+N+1 at the earliest.
- stall is high combinationally in the start cycle (before edge T) and through cycle T+N whenever d_md=1.
- An mfhi/mflo released after stall falls reads the new result.
- mthi/mtlo: the new value is visible on hi/lo and rd_data the cycle after the accept edge.
- Simultaneous reset and op: reset wins and the op is dropped.

## Test plan
- Reset, then no ops: hi=lo=0, busy=0, stall=0 held.
- mult a=0xFFFFFFFD, b=7 with default parameters:
  - busy is high for exactly 5 cycles.
  - At completion hi=0xFFFFFFFF, lo=0xFFFFFFEB.
  - d_md=1 throughout gives stall high from the start cycle through the last busy cycle.
- multu a=0xFFFFFFFF, b=2 gives hi=0x00000001, lo=0xFFFFFFFE. div a=0xFFFFFFF9, b=2 gives lo=0xFFFFFFFD, hi=0xFFFFFFFF after exactly 10 busy cycles.
- mtlo a=0x1234 then divu a=7, b=0:
  - lo=0x1234 before the divu.
  - busy is high 10 cycles.
  - hi/lo are unchanged afterwards.
  - Follow with divu 7/2: lo=3, hi=1.
- During RUN, drive op=101 with a=0xDEAD: hi is not 0xDEAD at any point and the pending result commits normally.
- Start a div, assert reset on its 4th busy cycle: the next cycle shows busy=0 and hi=lo=0, and no late commit appears in the following 10 cycles.

Source files
------------

// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if: E-stage request, D-stage hazard and HI/LO read signals
// shared between the pipeline (master) and the multiply/divide controller
// (slave).
//   op      E-stage operation code (mult/multu/div/divu/mthi/mtlo)
//   a, b    forwarded rs/rt operands
//   d_md    D-stage instruction touches the multiply/divide unit
//   rd_sel  HI/LO read select (0 LO, 1 HI)
//   rd_data selected HI/LO value
//   busy    operation in flight
//   stall   stall request to the hazard unit
//   hi, lo  architectural HI/LO registers
interface muldiv_ctrl_if;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        d_md;
    logic        rd_sel;
    logic [31:0] rd_data;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output op, a, b, d_md, rd_sel,
        input  rd_data, busy, stall, hi, lo
    );

    modport slave (
        input  op, a, b, d_md, rd_sel,
        output rd_data, busy, stall, hi, lo
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle multiply/divide controller holding HI/LO.
// The result is computed when the operation is accepted, parked in pending
// registers and committed to HI/LO after a fixed busy latency.
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   md     slave side of muldiv_ctrl_if (op/a/b/d_md/rd_sel in,
//          rd_data/busy/stall/hi/lo out)
module muldiv_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_ctrl_if.slave md
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    logic [0:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic               is_mul, is_div, start;
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic               a_neg, b_neg;
    logic        [31:0] a_mag, b_mag, q_mag, r_mag, quo, rem;
    logic        [31:0] res_hi, res_lo;

    always_comb begin
        is_mul = (md.op == OP_MULT) || (md.op == OP_MULTU);
        is_div = (md.op == OP_DIV)  || (md.op == OP_DIVU);
        start  = (state_q == IDLE) && (is_mul || is_div);

        prod_s = $signed(md.a) * $signed(md.b);
        prod_u = {32'd0, md.a} * {32'd0, md.b};

        // Signed divide runs on magnitudes through the same unsigned divider;
        // this also yields 0x80000000 / -1 = 0x80000000 rem 0 without overflow.
        a_neg = (md.op == OP_DIV) && md.a[31];
        b_neg = (md.op == OP_DIV) && md.b[31];
        a_mag = a_neg ? -md.a : md.a;
        b_mag = b_neg ? -md.b : md.b;
        q_mag = (b_mag != 32'd0) ? (a_mag / b_mag) : '0;
        r_mag = (b_mag != 32'd0) ? (a_mag % b_mag) : '0;
        quo   = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem   = a_neg ? -r_mag : r_mag;

        res_hi = hi_q;
        res_lo = lo_q;
        if (md.op == OP_MULT) begin
            res_hi = prod_s[63:32];
            res_lo = prod_s[31:0];
        end else if (md.op == OP_MULTU) begin
            res_hi = prod_u[63:32];
            res_lo = prod_u[31:0];
        end else if (is_div && (md.b != 32'd0)) begin
            res_hi = rem;
            res_lo = quo;
        end
        // Divide by zero parks the current HI/LO as the pending result, so the
        // commit leaves them unchanged (they cannot be written while RUN).
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        if (state_q == IDLE) begin
            if (start) begin
                pend_hi_d = res_hi;
                pend_lo_d = res_lo;
                cnt_d     = is_mul ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
                state_d   = RUN;
            end else if (md.op == OP_MTHI) begin
                hi_d = md.a;
            end else if (md.op == OP_MTLO) begin
                lo_d = md.a;
            end
        end else begin
            // Any op arriving while RUN is ignored.
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                hi_d    = pend_hi_q;
                lo_d    = pend_lo_q;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign md.busy    = (state_q == RUN);
    assign md.stall   = md.d_md && ((state_q == RUN) || start);
    assign md.rd_data = md.rd_sel ? hi_q : lo_q;
    assign md.hi      = hi_q;
    assign md.lo      = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: self-checking bench for muldiv_ctrl with default latencies
// (mult 5, div 10). Expected HI/LO results are pushed to a scoreboard queue
// when an operation is issued and popped when busy falls.
module tb_muldiv_ctrl;
    logic clk = 1'b0;
    logic reset;

    muldiv_ctrl_if bus ();

    muldiv_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus.slave)
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [63:0] exp_q[$];
    logic [31:0] mhi = '0;
    logic [31:0] mlo = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference {hi,lo} computed with 64-bit integer arithmetic.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x,
                                          input logic [31:0] y, input logic [31:0] ph,
                                          input logic [31:0] pl);
        longint          sx, sy, q, r;
        longint unsigned ux, uy, uq, ur;
        logic [63:0]     p;
        sx = longint'(signed'(x));
        sy = longint'(signed'(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        p  = {ph, pl};
        case (o)
            3'b001: p = 64'(sx * sy);
            3'b010: p = ux * uy;
            3'b011: if (y != 32'd0) begin
                q = sx / sy;
                r = sx % sy;
                p = {r[31:0], q[31:0]};
            end
            3'b100: if (y != 32'd0) begin
                uq = ux / uy;
                ur = ux % uy;
                p = {ur[31:0], uq[31:0]};
            end
            default: ;
        endcase
        return p;
    endfunction

    // Issue a long op at a negedge; optionally inject another op on the
    // second busy cycle. Returns at the negedge of the first idle cycle.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic dm, input logic [2:0] inj, input int unsigned n);
        int unsigned cyc;
        logic [63:0] e;
        bus.op   = o;
        bus.a    = x;
        bus.b    = y;
        bus.d_md = dm;
        #1;
        chk("stall_start", 64'(bus.stall), 64'(dm));
        exp_q.push_back(model(o, x, y, mhi, mlo));
        @(negedge clk);
        bus.op = 3'b000;
        cyc = 0;
        while (bus.busy && cyc < 40) begin
            chk("hold_hi", 64'(bus.hi), 64'(mhi));
            chk("hold_lo", 64'(bus.lo), 64'(mlo));
            chk("stall_run", 64'(bus.stall), 64'(dm));
            if (cyc == 1 && inj != 3'b000) begin
                bus.op = inj;
                bus.a  = 32'hDEAD;
                bus.b  = 32'd3;
            end else begin
                bus.op = 3'b000;
            end
            cyc++;
            @(negedge clk);
        end
        bus.op = 3'b000;
        chk("busy_len", 64'(cyc), 64'(n));
        e   = exp_q.pop_front();
        mhi = e[63:32];
        mlo = e[31:0];
        chk("res_hi", 64'(bus.hi), 64'(mhi));
        chk("res_lo", 64'(bus.lo), 64'(mlo));
        chk("stall_idle", 64'(bus.stall), 64'd0);
        bus.rd_sel = 1'b1;
        #1;
        chk("rd_hi", 64'(bus.rd_data), 64'(mhi));
        bus.rd_sel = 1'b0;
        #1;
        chk("rd_lo", 64'(bus.rd_data), 64'(mlo));
    endtask

    task automatic move_to(input logic [2:0] o, input logic [31:0] x);
        bus.op = o;
        bus.a  = x;
        #1;
        chk("mt_nobusy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        bus.op = 3'b000;
        if (o == 3'b101) mhi = x;
        else mlo = x;
        chk("mt_busy", 64'(bus.busy), 64'd0);
        chk("mt_hi", 64'(bus.hi), 64'(mhi));
        chk("mt_lo", 64'(bus.lo), 64'(mlo));
        bus.rd_sel = (o == 3'b101);
        #1;
        chk("mt_rd", 64'(bus.rd_data), 64'(x));
        bus.rd_sel = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0]  o;
        logic [31:0] x, y;
        reset      = 1'b1;
        bus.op     = 3'b000;
        bus.a      = '0;
        bus.b      = '0;
        bus.d_md   = 1'b0;
        bus.rd_sel = 1'b0;
        repeat (3) @(negedge clk);
        reset    = 1'b0;
        bus.d_md = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_hi", 64'(bus.hi), 64'd0);
            chk("rst_lo", 64'(bus.lo), 64'd0);
            chk("rst_busy", 64'(bus.busy), 64'd0);
            chk("rst_stall", 64'(bus.stall), 64'd0);
            chk("rst_rd", 64'(bus.rd_data), 64'd0);
            @(negedge clk);
        end

        run_op(3'b001, 32'hFFFFFFFD, 32'd7, 1'b1, 3'b000, 5);
        chk("mult_hi", 64'(bus.hi), 64'h0000_0000_FFFF_FFFF);
        chk("mult_lo", 64'(bus.lo), 64'h0000_0000_FFFF_FFEB);

        run_op(3'b010, 32'hFFFFFFFF, 32'd2, 1'b0, 3'b000, 5);
        chk("multu_hi", 64'(bus.hi), 64'h1);
        chk("multu_lo", 64'(bus.lo), 64'hFFFF_FFFE);

        run_op(3'b011, 32'hFFFFFFF9, 32'd2, 1'b1, 3'b000, 10);
        chk("div_lo", 64'(bus.lo), 64'hFFFF_FFFD);
        chk("div_hi", 64'(bus.hi), 64'hFFFF_FFFF);

        move_to(3'b110, 32'h1234);
        chk("mtlo_val", 64'(bus.lo), 64'h1234);
        run_op(3'b100, 32'd7, 32'd0, 1'b1, 3'b000, 10);
        chk("div0_hi", 64'(bus.hi), 64'hFFFF_FFFF);
        chk("div0_lo", 64'(bus.lo), 64'h1234);
        run_op(3'b100, 32'd7, 32'd2, 1'b0, 3'b000, 10);
        chk("divu_lo", 64'(bus.lo), 64'd3);
        chk("divu_hi", 64'(bus.hi), 64'd1);

        run_op(3'b011, 32'h80000000, 32'hFFFFFFFF, 1'b1, 3'b000, 10);
        chk("ovf_lo", 64'(bus.lo), 64'h8000_0000);
        chk("ovf_hi", 64'(bus.hi), 64'd0);

        // mthi and a second start while RUN are both ignored
        run_op(3'b001, 32'd6, 32'd9, 1'b1, 3'b101, 5);
        chk("inj_hi", 64'(bus.hi), 64'd0);
        chk("inj_lo", 64'(bus.lo), 64'd54);
        run_op(3'b011, 32'd100, 32'hFFFFFFF9, 1'b1, 3'b001, 10);
        chk("inj2_lo", 64'(bus.lo), 64'hFFFF_FFF2);
        chk("inj2_hi", 64'(bus.hi), 64'd2);

        move_to(3'b101, 32'h5555);

        for (int i = 0; i < 8; i++) begin
            o = 3'($urandom_range(1, 4));
            x = $urandom;
            y = $urandom;
            if (i % 3 == 1) y = y >> 24;
            run_op(o, x, y, 1'($urandom_range(0, 1)), 3'b000, (o <= 3'b010) ? 5 : 10);
        end

        // reset on the 4th busy cycle of a div aborts it
        bus.op   = 3'b011;
        bus.a    = 32'd1000;
        bus.b    = 32'd7;
        bus.d_md = 1'b0;
        @(negedge clk);
        bus.op = 3'b000;
        repeat (3) @(negedge clk);
        chk("abort_busy4", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mhi = '0;
        mlo = '0;
        for (int i = 0; i < 11; i++) begin
            chk("abort_busy", 64'(bus.busy), 64'd0);
            chk("abort_hi", 64'(bus.hi), 64'd0);
            chk("abort_lo", 64'(bus.lo), 64'd0);
            @(negedge clk);
        end

        // reset together with an op drops the op
        bus.op = 3'b001;
        bus.a  = 32'd5;
        bus.b  = 32'd5;
        reset  = 1'b1;
        @(negedge clk);
        bus.op = 3'b101;
        @(negedge clk);
        reset  = 1'b0;
        bus.op = 3'b000;
        chk("rstop_busy", 64'(bus.busy), 64'd0);
        chk("rstop_hi", 64'(bus.hi), 64'd0);
        @(negedge clk);
        chk("rstop_busy2", 64'(bus.busy), 64'd0);
        chk("rstop_lo", 64'(bus.lo), 64'd0);

        // back-to-back from a clean state
        run_op(3'b010, 32'd3, 32'd4, 1'b1, 3'b000, 5);
        run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 3'b000, 5);
        chk("b2b_lo", 64'(bus.lo), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
